// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART transmitter: FSM encoding and divisor floor.
// Imported by uart_tx_cfg; the FIFO is type-agnostic and does not depend on it.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    // Divisor values below this are clamped up so every bit lasts at least two cycles.
    localparam int unsigned MIN_DIV = 2;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO, power-of-two depth, show-ahead read (head valid while not empty).
// Push ignored when full, pop ignored when empty; a pushed entry is visible one cycle later.
module uart_sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (level == (AW+1)'(DEPTH));
    assign empty    = (level == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers are exactly AW bits wide, so increment wraps modulo DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// UART transmitter with TX FIFO and per-frame latched divisor/stop/parity; frame starts one cycle after pop.
// wr_ready drops only when the FIFO is full. Parity hardware exists only when UART_TX_PARITY_EN is defined.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_W      = 16
) (
    input  logic                          PCLK,
    input  logic                          PRESET,
    input  logic [DIV_W-1:0]              div,
    input  logic                          cfg_stop2,
    input  logic                          cfg_par_en,
    input  logic                          cfg_par_odd,
    input  logic                          wr_valid,
    input  logic [DATA_BITS-1:0]          wr_data,
    output logic                          wr_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          tx_busy,
    output logic                          tx_done,
    output logic                          tx_serial
);

    localparam int BW = $clog2(DATA_BITS + 1);

    uart_state_t          state;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_pop;
    logic [DATA_BITS-1:0] head;
    logic [DATA_BITS-1:0] shift;
    logic [DIV_W-1:0]     div_eff;
    logic [DIV_W-1:0]     div_l;
    logic [DIV_W-1:0]     cnt;
    logic [BW-1:0]        bit_idx;
    logic                 stop2_l;
    logic                 stop_second;
    logic                 bit_end;

`ifdef UART_TX_PARITY_EN
    logic                 par_en_l;
    logic                 par_bit;
`else
    logic                 unused_par;
    assign unused_par = cfg_par_en ^ cfg_par_odd;
`endif

    assign wr_ready = !fifo_full;
    assign fifo_pop = (state == IDLE) && !fifo_empty;
    assign div_eff  = (div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : div;
    assign bit_end  = (cnt == div_l - 1'b1);

    uart_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk       (PCLK),
        .rst       (PRESET),
        .push      (wr_valid && wr_ready),
        .push_data (wr_data),
        .pop       (fifo_pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state       <= IDLE;
            tx_serial   <= 1'b1;
            tx_busy     <= 1'b0;
            tx_done     <= 1'b0;
            shift       <= '0;
            div_l       <= DIV_W'(MIN_DIV);
            cnt         <= '0;
            bit_idx     <= '0;
            stop2_l     <= 1'b0;
            stop_second <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_en_l    <= 1'b0;
            par_bit     <= 1'b0;
`endif
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    tx_serial <= 1'b1;
                    cnt       <= '0;
                    if (!fifo_empty) begin
                        // Snapshot all framing config so mid-frame changes only affect later frames.
                        shift     <= head;
                        div_l     <= div_eff;
                        stop2_l   <= cfg_stop2;
`ifdef UART_TX_PARITY_EN
                        par_en_l  <= cfg_par_en;
                        par_bit   <= (^head) ^ cfg_par_odd;
`endif
                        tx_serial <= 1'b0;
                        tx_busy   <= 1'b1;
                        state     <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        cnt       <= '0;
                        tx_serial <= shift[0];
                        shift     <= shift >> 1;
                        bit_idx   <= '0;
                        state     <= DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cnt <= '0;
                        if (bit_idx == BW'(DATA_BITS - 1)) begin
                            stop_second <= 1'b0;
`ifdef UART_TX_PARITY_EN
                            if (par_en_l) begin
                                tx_serial <= par_bit;
                                state     <= PARITY;
                            end else begin
                                tx_serial <= 1'b1;
                                state     <= STOP;
                            end
`else
                            tx_serial <= 1'b1;
                            state     <= STOP;
`endif
                        end else begin
                            tx_serial <= shift[0];
                            shift     <= shift >> 1;
                            bit_idx   <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        cnt         <= '0;
                        tx_serial   <= 1'b1;
                        stop_second <= 1'b0;
                        state       <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        cnt <= '0;
                        if (stop2_l && !stop_second) begin
                            stop_second <= 1'b1;
                        end else begin
                            tx_busy <= 1'b0;
                            tx_done <= 1'b1;
                            state   <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    tx_serial <= 1'b1;
                    tx_busy   <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: frame table plus back-to-back, FIFO-full, reset-abort and divisor-change sequences.
module tb_uart_tx_cfg;

    localparam int DB = 8;
    localparam int FD = 4;
    localparam int DW = 16;

    logic          PCLK = 1'b0;
    logic          PRESET;
    logic [DW-1:0] div;
    logic          cfg_stop2;
    logic          cfg_par_en;
    logic          cfg_par_odd;
    logic          wr_valid;
    logic [DB-1:0] wr_data;
    logic          wr_ready;
    logic [2:0]    fifo_level;
    logic          tx_busy;
    logic          tx_done;
    logic          tx_serial;

    int n_cmp = 0;
    int n_bad = 0;

    uart_tx_cfg #(
        .DATA_BITS  (DB),
        .FIFO_DEPTH (FD),
        .DIV_W      (DW)
    ) dut (
        .PCLK        (PCLK),
        .PRESET      (PRESET),
        .div         (div),
        .cfg_stop2   (cfg_stop2),
        .cfg_par_en  (cfg_par_en),
        .cfg_par_odd (cfg_par_odd),
        .wr_valid    (wr_valid),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .fifo_level  (fifo_level),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .tx_serial   (tx_serial)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        logic [7:0]  data;
        logic [15:0] dv;
        int          dv_eff;
        logic        stop2;
        logic        par_en;
        logic        par_odd;
        int          len;
        logic [15:0] bits;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic write_byte(input logic [7:0] d);
        wr_data  = d;
        wr_valid = 1'b1;
        @(posedge PCLK);
        #1;
        wr_valid = 1'b0;
    endtask

    // Waits for a start bit, then samples every cycle of nbits bit periods plus the following idle cycle.
    task automatic capture(input int dv, input int nbits, output logic [15:0] bits,
                           output int bad, output int waited, output logic [2:0] idle);
        bit found;
        bits   = '0;
        bad    = 0;
        waited = 0;
        idle   = '0;
        found  = 1'b0;
        for (int t = 0; t < 400; t++) begin
            @(negedge PCLK);
            waited++;
            if (tx_serial == 1'b0) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            bad = 1000;
        end else begin
            for (int k = 0; k < nbits; k++) begin
                for (int c = 0; c < dv; c++) begin
                    if (k != 0 || c != 0) @(negedge PCLK);
                    if (c == 0) bits[k] = tx_serial;
                    else if (tx_serial !== bits[k]) bad++;
                    if (tx_busy !== 1'b1 || tx_done !== 1'b0) bad++;
                end
            end
            @(negedge PCLK);
            idle = {tx_serial, tx_busy, tx_done};
        end
    endtask

    logic [15:0] cap_bits;
    int          cap_bad;
    int          cap_wait;
    logic [2:0]  cap_idle;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [7:0] lvl_seen [6];
        logic       rdy_seen [6];
        int         seen;
        bit         got;

        vecs[0] = '{8'hA5, 16'd4, 4, 1'b0, 1'b0, 1'b0, 10, 16'h034A};
        vecs[1] = '{8'h00, 16'd2, 2, 1'b0, 1'b0, 1'b0, 10, 16'h0200};
        vecs[2] = '{8'hFF, 16'd0, 2, 1'b0, 1'b0, 1'b0, 10, 16'h03FE};
        vecs[3] = '{8'h07, 16'd3, 3, 1'b1, 1'b0, 1'b0, 11, 16'h060E};
`ifdef UART_TX_PARITY_EN
        vecs[4] = '{8'h07, 16'd4, 4, 1'b0, 1'b1, 1'b0, 11, 16'h060E};
        vecs[5] = '{8'h07, 16'd4, 4, 1'b0, 1'b1, 1'b1, 11, 16'h040E};
        vecs[7] = '{8'h80, 16'd2, 2, 1'b1, 1'b1, 1'b0, 12, 16'h0F00};
`else
        vecs[4] = '{8'h07, 16'd4, 4, 1'b0, 1'b1, 1'b0, 10, 16'h020E};
        vecs[5] = '{8'h07, 16'd4, 4, 1'b0, 1'b1, 1'b1, 10, 16'h020E};
        vecs[7] = '{8'h80, 16'd2, 2, 1'b1, 1'b1, 1'b0, 11, 16'h0700};
`endif
        vecs[6] = '{8'h5A, 16'd1, 2, 1'b0, 1'b0, 1'b0, 10, 16'h02B4};

        PRESET      = 1'b1;
        div         = 16'd4;
        cfg_stop2   = 1'b0;
        cfg_par_en  = 1'b0;
        cfg_par_odd = 1'b0;
        wr_valid    = 1'b0;
        wr_data     = '0;
        repeat (3) @(posedge PCLK);
        @(negedge PCLK);
        check("reset_outputs", {28'd0, tx_serial, tx_busy, tx_done, wr_ready}, 32'b1001);
        check("reset_level", {29'd0, fifo_level}, 32'd0);
        @(posedge PCLK);
        #1;
        PRESET = 1'b0;
        repeat (2) @(posedge PCLK);
        #1;

        // Single-frame table.
        for (int i = 0; i < 8; i++) begin
            div         = vecs[i].dv;
            cfg_stop2   = vecs[i].stop2;
            cfg_par_en  = vecs[i].par_en;
            cfg_par_odd = vecs[i].par_odd;
            write_byte(vecs[i].data);
            capture(vecs[i].dv_eff, vecs[i].len, cap_bits, cap_bad, cap_wait, cap_idle);
            check($sformatf("v%0d_bits", i), {16'd0, cap_bits}, {16'd0, vecs[i].bits});
            check($sformatf("v%0d_timing", i), cap_bad, 0);
            check($sformatf("v%0d_idle", i), {29'd0, cap_idle}, 32'b101);
            @(negedge PCLK);
            check($sformatf("v%0d_after", i), {29'd0, tx_serial, tx_busy, tx_done}, 32'b100);
            @(posedge PCLK);
            #1;
        end

        // Back-to-back, two stop bits, div 3.
        div = 16'd3; cfg_stop2 = 1'b1; cfg_par_en = 1'b0; cfg_par_odd = 1'b0;
        write_byte(8'h07);
        write_byte(8'h81);
        capture(3, 11, cap_bits, cap_bad, cap_wait, cap_idle);
        check("b2b_f1_bits", {16'd0, cap_bits}, 32'h060E);
        check("b2b_f1_timing", cap_bad, 0);
        check("b2b_f1_idle", {29'd0, cap_idle}, 32'b101);
        capture(3, 11, cap_bits, cap_bad, cap_wait, cap_idle);
        check("b2b_gap", cap_wait, 1);
        check("b2b_f2_bits", {16'd0, cap_bits}, 32'h0702);
        check("b2b_f2_timing", cap_bad, 0);
        check("b2b_f2_idle", {29'd0, cap_idle}, 32'b101);
        @(posedge PCLK);
        #1;

        // FIFO full: six writes, five accepted, sixth dropped.
        div = 16'd2; cfg_stop2 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            wr_data     = 8'h11 + 8'(i);
            wr_valid    = 1'b1;
            rdy_seen[i] = wr_ready;
            @(posedge PCLK);
            #1;
            lvl_seen[i] = {5'd0, fifo_level};
        end
        wr_valid = 1'b0;
        check("full_rdy0", {31'd0, rdy_seen[0]}, 32'd1);
        check("full_rdy4", {31'd0, rdy_seen[4]}, 32'd1);
        check("full_rdy5", {31'd0, rdy_seen[5]}, 32'd0);
        check("full_lvl0", {24'd0, lvl_seen[0]}, 32'd1);
        check("full_lvl1", {24'd0, lvl_seen[1]}, 32'd1);
        check("full_lvl3", {24'd0, lvl_seen[3]}, 32'd3);
        check("full_lvl5", {24'd0, lvl_seen[5]}, 32'd4);
        check("full_wr_ready", {31'd0, wr_ready}, 32'd0);
        got = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(negedge PCLK);
            if (tx_done) begin
                got = 1'b1;
                break;
            end
        end
        check("full_first_done", {31'd0, got}, 32'd1);
        for (int j = 0; j < 4; j++) begin
            capture(2, 10, cap_bits, cap_bad, cap_wait, cap_idle);
            check($sformatf("full_f%0d_bits", j + 2), {16'd0, cap_bits},
                  {22'd0, 1'b1, 8'h12 + 8'(j), 1'b0});
            check($sformatf("full_f%0d_timing", j + 2), cap_bad, 0);
            check($sformatf("full_f%0d_idle", j + 2), {29'd0, cap_idle}, 32'b101);
        end
        seen = 0;
        for (int t = 0; t < 60; t++) begin
            @(negedge PCLK);
            if (tx_busy || !tx_serial) seen++;
        end
        check("full_no_extra_frame", seen, 0);
        check("full_drained_level", {29'd0, fifo_level}, 32'd0);
        @(posedge PCLK);
        #1;

        // Reset during DATA bit 3 with a second byte still queued.
        div = 16'd4;
        write_byte(8'h00);
        write_byte(8'h33);
        got = 1'b0;
        for (int t = 0; t < 50; t++) begin
            @(negedge PCLK);
            if (!tx_serial) begin
                got = 1'b1;
                break;
            end
        end
        check("rst_frame_started", {31'd0, got}, 32'd1);
        repeat (17) @(negedge PCLK);
        check("rst_pre_line", {31'd0, tx_serial}, 32'd0);
        check("rst_pre_level", {29'd0, fifo_level}, 32'd1);
        PRESET = 1'b1;
        @(negedge PCLK);
        check("rst_mid_outputs", {28'd0, tx_serial, tx_busy, tx_done, wr_ready}, 32'b1001);
        check("rst_mid_level", {29'd0, fifo_level}, 32'd0);
        @(posedge PCLK);
        #1;
        PRESET = 1'b0;
        seen = 0;
        for (int t = 0; t < 40; t++) begin
            @(negedge PCLK);
            if (tx_done || tx_busy || !tx_serial) seen++;
        end
        check("rst_quiet", seen, 0);
        @(posedge PCLK);
        #1;
        write_byte(8'h3C);
        capture(4, 10, cap_bits, cap_bad, cap_wait, cap_idle);
        check("rst_after_bits", {16'd0, cap_bits}, 32'h0278);
        check("rst_after_timing", cap_bad, 0);
        check("rst_after_idle", {29'd0, cap_idle}, 32'b101);
        @(posedge PCLK);
        #1;

        // Divisor changed 4 -> 8 while the first frame is on the line.
        div = 16'd4;
        write_byte(8'h55);
        write_byte(8'h55);
        fork
            capture(4, 10, cap_bits, cap_bad, cap_wait, cap_idle);
            begin
                repeat (12) @(posedge PCLK);
                #1;
                div = 16'd8;
            end
        join
        check("div_f1_bits", {16'd0, cap_bits}, 32'h02AA);
        check("div_f1_timing", cap_bad, 0);
        check("div_f1_idle", {29'd0, cap_idle}, 32'b101);
        capture(8, 10, cap_bits, cap_bad, cap_wait, cap_idle);
        check("div_f2_gap", cap_wait, 1);
        check("div_f2_bits", {16'd0, cap_bits}, 32'h02AA);
        check("div_f2_timing", cap_bad, 0);
        check("div_f2_idle", {29'd0, cap_idle}, 32'b101);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_cfg.md
UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, data bits per frame; legal range 5..9.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, transmit FIFO entries; power of two, >= 2.
REQ-003 SHALL have parameter DIV_W, default 16, width of the baud divisor input.
REQ-004 SHALL have port PCLK  in  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port PRESET  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port div  in  DIV_W  PCLK cycles per bit; values 0 and 1 treated as 2.
REQ-007 SHALL have port cfg_stop2  in  1  1 = two stop bits, 0 = one stop bit.
REQ-008 SHALL have port cfg_par_en  in  1  parity bit enable.
REQ-009 SHALL have port cfg_par_odd  in  1  1 = odd parity, 0 = even parity.
REQ-010 SHALL have port wr_valid  in  1  write request.
REQ-011 SHALL have port wr_data  in  DATA_BITS  byte to queue.
REQ-012 SHALL have port wr_ready  out  1  FIFO not full.
REQ-013 SHALL have port fifo_level  out  clog2(FIFO_DEPTH)+1  entries queued.
REQ-014 SHALL have port tx_busy  out  1  frame in progress.
REQ-015 SHALL have port tx_done  out  1  one-cycle pulse per completed frame.
REQ-016 SHALL have port tx_serial  out  1  serial line; idle high.

Function
REQ-017 SHALL push wr_data when wr_valid && wr_ready; wr_ready = !full, independent of same-cycle pop.
REQ-018 SHALL ignore wr_valid while full, with no FIFO or level change.
REQ-019 SHALL use FSM states IDLE, START, DATA, PARITY, STOP.
REQ-020 IDLE: with FIFO non-empty, SHALL pop the head, latch div, cfg_stop2, cfg_par_en and cfg_par_odd, then go to START next cycle.
REQ-021 Config and div changes mid-frame SHALL NOT affect the frame in progress.
REQ-022 Each bit SHALL hold for exactly the latched div cycles: START drives 0, then DATA bits LSB first, then PARITY if enabled, then STOP drives 1 for one or two bit periods.
REQ-023 The parity bit SHALL be XOR of the data bits, inverted when odd parity is selected.
REQ-024 SHALL assert tx_done for one cycle on the cycle IDLE is re-entered; tx_busy SHALL be 1 in every non-IDLE state.
REQ-025 Back-to-back frames SHALL be separated by exactly one IDLE cycle of line-high.
REQ-026 fifo_level SHALL change by +1 on push, -1 on pop, and 0 on simultaneous push and pop.
REQ-027 A push into an empty FIFO SHALL be poppable no earlier than the following cycle.
REQ-028 FIFO pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-029 PRESET SHALL, at any point including mid-frame, force IDLE, empty the FIFO, and set tx_serial=1, tx_busy=0, tx_done=0, wr_ready=1, fifo_level=0; an aborted frame SHALL produce no tx_done.

Configuration
REQ-030 Macro UART_TX_PARITY_EN defined: the PARITY state and cfg_par_en/cfg_par_odd SHALL be functional.
REQ-031 Macro UART_TX_PARITY_EN undefined: the parity ports SHALL remain but be ignored, and the PARITY state and parity logic SHALL not be synthesised.

Structure
REQ-032 A shared package uart_pkg SHALL hold the FSM state encoding and the minimum divisor constant (2).
REQ-033 The FIFO SHALL be a sub-module uart_sync_fifo (DEPTH and WIDTH parameters), instantiated once.

Verification
REQ-034 DATA_BITS=8, div=4, no parity, 1 stop, write 0xA5 -> line 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; one tx_done pulse.
REQ-035 Parity even, then odd, write 0x07 -> parity bit 1 (even), 0 (odd); frame 11 bits; macro undefined -> 10 bits.
REQ-036 cfg_stop2=1, div=3 -> stop high for 6 cycles, then 1 IDLE cycle, then next START.
REQ-037 FIFO_DEPTH=4, 6 consecutive writes while busy -> 4 accepted (first popped immediately, so 5 total accepted), wr_ready low at full, rejected bytes never sent.
REQ-038 PRESET asserted during DATA bit 3 -> next cycle tx_serial=1, fifo_level=0, no tx_done; new write transmits cleanly.
REQ-039 div changed 4->8 mid-frame -> current frame stays at 4 cycles/bit, next frame uses 8.
